rom_fetch_streamer: RTL and testbench

//  Reader side of the synchronous ROM port (registered read, 1-cycle latency). On start, walks LEN

---
 rtl/rom_fetch_streamer_pkg.sv | 10 +
 rtl/rom_fetch_streamer_skid_fifo.sv | 45 ++++
 rtl/rom_fetch_streamer.sv | 111 +++++++++++
 tb/tb_rom_fetch_streamer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_streamer_pkg.sv
// Shared defaults and FSM state type for the ROM fetch streamer.
package rom_fetch_pkg;
  localparam int unsigned ROM_ADDR_W    = 5;
  localparam int unsigned ROM_DATA_W    = 32;
  localparam int unsigned ROM_DEPTH     = 16;
  localparam int unsigned ROM_LEN_W     = 5;
  localparam int unsigned ROM_BUF_DEPTH = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/rom_fetch_streamer_skid_fifo.sv
// Small FIFO of {addr,data} words absorbing ROM read latency under backpressure.
module fetch_skid_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned W     = 8,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/rom_fetch_streamer.sv
// Walks LEN consecutive ROM addresses (wrapping at DEPTH) and streams the words
// out over valid/ready, with credit-limited reads so backpressure never drops data.
module rom_fetch_streamer
  import rom_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = ROM_ADDR_W,
  parameter int unsigned DATA_W    = ROM_DATA_W,
  parameter int unsigned DEPTH     = ROM_DEPTH,
  parameter int unsigned LEN_W     = ROM_LEN_W,
  parameter int unsigned BUF_DEPTH = ROM_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, issued_q, popped_q;
  logic [1:0]         rd_v_q;
  logic [ADDR_W-1:0]  rd_a1_q;
  logic [CW-1:0]      count;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [1:0]         inflight;
  logic [3:0]         used, avail;
  logic               pop, push, accept, issue, credit_ok, last_pop;
  logic [ADDR_W-1:0]  base_mod;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign base_mod = base_addr % ADDR_W'(DEPTH);
  assign out_valid = (count != '0);
  assign out_addr  = head[ADDR_W+DATA_W-1:DATA_W];
  assign out_data  = head[DATA_W-1:0];
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign push      = rd_v_q[1];

  always_comb begin
    pop       = out_valid & out_ready;
    inflight  = 2'(rd_v_q[0]) + 2'(rd_v_q[1]);
    used      = 4'(count) + 4'(inflight);
    avail     = 4'(BUF_DEPTH) + 4'(pop);
    credit_ok = used < avail;
    accept    = (state_q == IDLE) && start;
    // The first read goes out on the accepting edge so rom_addr=base in the next cycle.
    issue     = (accept && (length != '0)) ||
                ((state_q == RUN) && (issued_q < len_q) && credit_ok);
    last_pop  = (state_q == RUN) && pop && (popped_q == len_q - LEN_W'(1));
    state_d   = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (length != '0) ? RUN : DONE;
      RUN:     if (last_pop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      rom_addr <= '0;
      rd_v_q   <= '0;
      rd_a1_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_v_q  <= {rd_v_q[0], issue};
      if (rd_v_q[0]) rd_a1_q <= rom_addr;
      if (accept) begin
        len_q    <= length;
        popped_q <= '0;
        issued_q <= (length != '0) ? LEN_W'(1) : '0;
        if (length != '0) rom_addr <= base_mod;
      end else if (state_q == RUN) begin
        if (issue) begin
          issued_q <= issued_q + 1'b1;
          rom_addr <= next_addr(rom_addr);
        end
        if (pop) popped_q <= popped_q + 1'b1;
      end
    end
  end

  fetch_skid_fifo #(
    .DEPTH(BUF_DEPTH),
    .W    (ADDR_W + DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({rd_a1_q, rom_data}),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );
endmodule

// File: tb/tb_rom_fetch_streamer.sv
// Scoreboard bench: expected {addr,data} words are queued at start, a monitor pops on each transfer.
module tb_rom_fetch_streamer;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, out_valid, out_ready;
  logic [AW-1:0] base_addr, rom_addr, out_addr;
  logic [4:0]    length;
  logic [DW-1:0] rom_data, out_data;
  logic [DW-1:0] rom_mem [32];

  int tests = 0;
  int fails = 0;
  int xfer_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rom_fetch_streamer #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .LEN_W(5), .BUF_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  // Registered-read ROM: data appears the cycle after the address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [AW+DW-1:0] e;
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected word: got addr %0h data %0h expected none", out_addr, out_data);
      end else begin
        e = exp_q.pop_front();
        check("stream addr", 64'(out_addr), 64'(e[AW+DW-1:DW]));
        check("stream data", 64'(out_data), 64'(e[DW-1:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected words from the address-walk rule: (base mod 16 + k) mod 16, data = addr + 1.
  task automatic start_burst(input int b, input int l);
    for (int k = 0; k < l; k++) begin
      automatic int a = ((b % 16) + k) % 16;
      exp_q.push_back({AW'(a), DW'(a + 1)});
    end
    base_addr = AW'(b);
    length    = 5'(l);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int l, input bit rand_ready);
    bit seen = 1'b0;
    bit last_xfer = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        check({name, " busy at done"}, 64'(busy), 64'(0));
        check({name, " words left"}, 64'(exp_q.size()), 64'(0));
        if (l != 0) check({name, " done after last xfer"}, 64'(last_xfer), 64'(1));
      end else begin
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        last_xfer = out_valid && out_ready;
        step();
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: done got 0 expected 1 within 400 cycles", name);
    end else begin
      step();
      check({name, " done width"}, 64'(done), 64'(0));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " busy"},      64'(busy),      64'(0));
    check({name, " done"},      64'(done),      64'(0));
    check({name, " rom_addr"},  64'(rom_addr),  64'(0));
    check({name, " out_valid"}, 64'(out_valid), 64'(0));
    check({name, " out_data"},  64'(out_data),  64'(0));
    check({name, " out_addr"},  64'(out_addr),  64'(0));
  endtask

  initial begin
    logic [AW-1:0] ra;
    for (int i = 0; i < 32; i++) rom_mem[i] = (i < 16) ? DW'(i + 1) : (32'hBAD0_0000 | DW'(i));
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; length = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Full table walk with the consumer always ready.
    out_ready = 1'b1;
    start_burst(0, 16);
    check("t1 busy c1", 64'(busy), 64'(1));
    check("t1 rom_addr c1", 64'(rom_addr), 64'(0));
    check("t1 valid c1", 64'(out_valid), 64'(0));
    step();
    check("t1 valid c2", 64'(out_valid), 64'(0));
    step();
    check("t1 valid c3", 64'(out_valid), 64'(1));
    check("t1 data c3", 64'(out_data), 64'(1));
    wait_done("t1", 16, 1'b0);

    // Wrap past DEPTH-1.
    start_burst(14, 4);
    wait_done("t2", 4, 1'b0);

    // Stall: head must hold, and only two reads may be in the system.
    out_ready = 1'b0;
    start_burst(0, 8);
    step();
    step();
    for (int c = 3; c < 8; c++) begin
      check("t3 stall valid", 64'(out_valid), 64'(1));
      check("t3 stall data", 64'(out_data), 64'(1));
      check("t3 stall addr", 64'(out_addr), 64'(0));
      step();
    end
    check("t3 reads while stalled", 64'(rom_addr), 64'(1));
    out_ready = 1'b1;
    wait_done("t3", 8, 1'b0);

    // Zero-length burst.
    ra = rom_addr;
    start_burst(7, 0);
    check("t4 done c1", 64'(done), 64'(1));
    check("t4 busy c1", 64'(busy), 64'(0));
    check("t4 valid c1", 64'(out_valid), 64'(0));
    check("t4 rom_addr held", 64'(rom_addr), 64'(ra));
    step();
    check("t4 done c2", 64'(done), 64'(0));
    check("t4 valid c2", 64'(out_valid), 64'(0));

    // Reset mid-burst, then a fresh burst must show no stale words.
    begin
      int target;
      target = xfer_cnt + 3;
      start_burst(3, 10);
      for (int i = 0; i < 100 && xfer_cnt < target; i++) step();
      check("t5 three words seen", 64'(xfer_cnt >= target), 64'(1));
    end
    rst = 1'b1;
    step();
    check_reset_outputs("t5 reset");
    rst = 1'b0;
    exp_q.delete();
    start_burst(5, 2);
    wait_done("t5 restart", 2, 1'b0);

    // Start while busy must be ignored.
    start_burst(0, 6);
    base_addr = 5'd9; length = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t6", 6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t6 no extra burst", 64'(out_valid | busy), 64'(0));
      step();
    end

    // Random bursts with random backpressure.
    for (int n = 0; n < 20; n++) begin
      int b, l;
      b = $urandom_range(0, 31);
      l = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      out_ready = ($urandom_range(0, 1) != 0);
      start_burst(b, l);
      wait_done("rand", l, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
